// File: rtl/cpu_core_p.sv
// rtl/cpu_core_p.sv - parametrised multi-cycle fetch/execute CPU core
//
// Purpose: two-state (FETCH/EXEC) CPU with a 32-bit instruction word, a
// DATA_W-bit register file, Z/C/N flags, conditional branches, an optional
// CALL/RET return-address stack and terminal HALT/FAULT states.
//
// Optional feature macro: CPU_CALL_STACK_EN
//   defined   - CALL/RET use a STACK_DEPTH-entry stack; overflow/underflow -> FAULT
//   undefined - no stack storage, CALL/RET execute as NOP, fault tied low
//
// Ports:
//   clk, reset       clock (rising edge), synchronous active-high reset
//   enable           FSM advances only when high; all state holds otherwise
//   imem_addr/req    fetch address (= ip) and request (high throughout FETCH)
//   imem_data/valid  instruction word and its valid strobe
//   din, gpi         external data input and general-purpose inputs
//   dout/dout_valid  output register and its one-cycle OUT strobe
//   flags            {4'b0, halted, N, C, Z}
//   halted, fault    terminal-state indicator, sticky stack fault
module cpu_core_p #(
    parameter int DATA_W      = 8,
    parameter int REG_COUNT   = 16,
    parameter int IP_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [IP_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic [31:0]       imem_data,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] din,
    input  logic [3:0]        gpi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [7:0]        flags,
    output logic              halted,
    output logic              fault
);

    localparam int RIDX_W = $clog2(REG_COUNT);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hD;
    localparam logic [3:0] OP_JG   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [1:0]        state_q, state_d;
    logic [IP_W-1:0]   ip_q, ip_d, ip_inc, target;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic              z_q, z_d, c_q, c_d, n_q, n_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic [3:0]        opcode;
    logic [RIDX_W-1:0] rd_idx, ra_idx, rb_idx;
    logic [DATA_W-1:0] ra_val, rb_val, imm_val, alu_res;
    logic              alu_c;
    logic [DATA_W:0]   sum, diff;
    logic              unused_instr;

    assign opcode  = instr_q[31:28];
    assign rd_idx  = instr_q[24 +: RIDX_W];
    assign ra_idx  = instr_q[20 +: RIDX_W];
    assign rb_idx  = instr_q[16 +: RIDX_W];
    assign imm_val = instr_q[DATA_W-1:0];
    assign target  = instr_q[IP_W-1:0];
    assign ra_val  = regs_q[ra_idx];
    assign rb_val  = regs_q[rb_idx];
    assign ip_inc  = ip_q + IP_W'(1);
    assign unused_instr = ^instr_q;

`ifdef CPU_CALL_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    // Storage is rounded up to a power of two so the index width matches the
    // array; entries at or above STACK_DEPTH are never written.
    localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [IP_W-1:0] stack_q [1 << SI_W];
    logic [SP_W-1:0] sp_q, sp_d, sp_dec;
    logic [SI_W-1:0] push_idx, pop_idx;
    logic            push;
    logic            fault_q, fault_d;

    assign sp_dec   = sp_q - SP_W'(1);
    assign push_idx = sp_q[SI_W-1:0];
    assign pop_idx  = sp_dec[SI_W-1:0];
`endif

    // Borrow for SUB falls out of the extra MSB of the widened difference.
    always_comb begin
        sum     = {1'b0, ra_val} + {1'b0, rb_val};
        diff    = {1'b0, ra_val} - {1'b0, rb_val};
        alu_res = '0;
        alu_c   = 1'b0;
        case (opcode)
            OP_ADD: begin alu_res = sum[DATA_W-1:0];  alu_c = sum[DATA_W];    end
            OP_SUB: begin alu_res = diff[DATA_W-1:0]; alu_c = diff[DATA_W];   end
            OP_AND: alu_res = ra_val & rb_val;
            OP_OR:  alu_res = ra_val | rb_val;
            OP_XOR: alu_res = ra_val ^ rb_val;
            OP_SHL: begin alu_res = ra_val << 1;      alu_c = ra_val[DATA_W-1]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        instr_d   = instr_q;
        reg_we    = 1'b0;
        reg_wdata = '0;
        z_d       = z_q;
        c_d       = c_q;
        n_d       = n_q;
        dout_d    = dout_q;
`ifdef CPU_CALL_STACK_EN
        sp_d      = sp_q;
        push      = 1'b0;
        fault_d   = fault_q;
`endif
        if (enable) begin
            case (state_q)
                ST_FETCH: begin
                    if (imem_valid) begin
                        instr_d = imem_data;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_d = ST_FETCH;
                    ip_d    = ip_inc;
                    case (opcode)
                        OP_LDI: begin reg_we = 1'b1; reg_wdata = imm_val; end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
                            reg_we    = 1'b1;
                            reg_wdata = alu_res;
                            z_d       = (alu_res == '0);
                            n_d       = alu_res[DATA_W-1];
                            c_d       = alu_c;
                        end
                        OP_IN:  begin reg_we = 1'b1; reg_wdata = din; end
                        OP_OUT: dout_d = ra_val;
                        OP_JZ:  if (ra_val == '0) ip_d = target;
                        OP_JMP: ip_d = target;
                        OP_JG:  if ((gpi & instr_q[3:0]) != 4'b0) ip_d = target;
`ifdef CPU_CALL_STACK_EN
                        OP_CALL: begin
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                fault_d = 1'b1;
                                state_d = ST_FAULT;
                                ip_d    = ip_q;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + SP_W'(1);
                                ip_d = target;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                fault_d = 1'b1;
                                state_d = ST_FAULT;
                                ip_d    = ip_q;
                            end else begin
                                sp_d = sp_dec;
                                ip_d = stack_q[pop_idx];
                            end
                        end
`endif
                        OP_HALT: begin
                            state_d = ST_HALT;
                            ip_d    = ip_q;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ip_q    <= '0;
            instr_q <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            dout_q  <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
`ifdef CPU_CALL_STACK_EN
            sp_q    <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            instr_q <= instr_d;
            z_q     <= z_d;
            c_q     <= c_d;
            n_q     <= n_d;
            dout_q  <= dout_d;
            if (reg_we) begin
                regs_q[rd_idx] <= reg_wdata;
            end
`ifdef CPU_CALL_STACK_EN
            sp_q    <= sp_d;
            fault_q <= fault_d;
`endif
        end
    end

`ifdef CPU_CALL_STACK_EN
    // Return addresses need no reset: sp_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_q[push_idx] <= ip_inc;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Outputs are masked during the reset cycle so the board sees a clean
    // idle core even when reset lands mid-instruction.
    assign imem_addr  = reset ? '0 : ip_q;
    assign imem_req   = !reset && (state_q == ST_FETCH);
    assign dout       = dout_q;
    assign dout_valid = !reset && enable && (state_q == ST_EXEC) && (opcode == OP_OUT);
    assign halted     = !reset && ((state_q == ST_HALT) || (state_q == ST_FAULT));
    assign flags      = {4'b0, halted, n_q, c_q, z_q};

endmodule

// File: tb/tb_cpu_core_p.sv
// tb/tb_cpu_core_p.sv - directed self-checking bench for cpu_core_p
module tb_cpu_core_p;

    localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, ADD = 4'h2, SUB = 4'h3, AND_ = 4'h4;
    localparam logic [3:0] SHL = 4'h7, OUT = 4'h9, JZ = 4'hA, JMP = 4'hB, CALL = 4'hC;
    localparam logic [3:0] RET = 4'hD, JG = 4'hE, HLT = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [31:0] imem_data = 32'hDEAD_BEEF;
    logic        imem_valid = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [3:0]  gpi = 4'h0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [7:0]  flags;
    logic        halted;
    logic        fault;

    int total = 0;
    int bad = 0;

    logic [31:0] prog [0:255];
    int          lat = 0;
    int          wait_cnt = 0;
    logic [7:0]  fetch_log [$];
    int          pulse_cnt = 0;
    int          dv_off_cnt = 0;

    cpu_core_p #(
        .DATA_W(8), .REG_COUNT(16), .IP_W(8), .STACK_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_data(imem_data), .imem_valid(imem_valid),
        .din(din), .gpi(gpi), .dout(dout), .dout_valid(dout_valid),
        .flags(flags), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Instruction memory: answers a request after 'lat' idle negedges and
    // holds valid until the request drops.
    always @(negedge clk) begin
        if (!imem_req) begin
            imem_valid = 1'b0;
            imem_data  = 32'hDEAD_BEEF;
            wait_cnt   = 0;
        end else if (!imem_valid) begin
            if (wait_cnt >= lat) begin
                imem_valid = 1'b1;
                imem_data  = prog[imem_addr];
                fetch_log.push_back(imem_addr);
            end else begin
                wait_cnt++;
            end
        end
        if (dout_valid) pulse_cnt++;
        if (dout_valid && !enable) dv_off_cnt++;
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [15:0] imm);
        return {op, rd, ra, rb, imm};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = enc(HLT, 0, 0, 0, 0);
    endtask

    task automatic start(input int lat_i);
        reset  = 1'b1;
        enable = 1'b1;
        lat    = lat_i;
        @(posedge clk); #1;
        fetch_log.delete();
        pulse_cnt  = 0;
        dv_off_cnt = 0;
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n = 0;
        while (!halted && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!halted) begin
            bad++;
            $display("FAIL %s_timeout halted=%0b want=1 after %0d cycles", name, halted, n);
        end
    endtask

    task automatic load_basic();
        clear_prog();
        prog[0] = enc(LDI, 1, 0, 0, 16'd5);
        prog[1] = enc(LDI, 2, 0, 0, 16'd3);
        prog[2] = enc(ADD, 3, 1, 2, 0);
        prog[3] = enc(OUT, 0, 3, 0, 0);
    endtask

    task automatic test_reset();
        clear_prog();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", imem_req); end
        total++; if (imem_addr !== 8'd0) begin bad++; $display("FAIL rst_addr got=%0h want=0", imem_addr); end
        total++; if (dout !== 8'd0 || dout_valid !== 1'b0) begin bad++; $display("FAIL rst_dout got=%0h/%0b want=0/0", dout, dout_valid); end
        total++; if (flags !== 8'h00 || halted !== 1'b0 || fault !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0h/%0b/%0b want=0/0/0", flags, halted, fault); end
        reset = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_release_req got=%0b want=1", imem_req); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        load_basic();
        start(3);
        run_to_halt("basic");
        total++; if (dout !== 8'd8) begin bad++; $display("FAIL basic_dout got=%0h want=8", dout); end
        total++; if (pulse_cnt != 1) begin bad++; $display("FAIL basic_pulses got=%0d want=1", pulse_cnt); end
        total++; if (flags !== 8'h08) begin bad++; $display("FAIL basic_flags got=%0h want=08", flags); end
        total++;
        if (fetch_log.size() != 5 || fetch_log[0] != 0 || fetch_log[1] != 1 ||
            fetch_log[2] != 2 || fetch_log[3] != 3 || fetch_log[4] != 4) begin
            bad++; $display("FAIL basic_addr_seq got=%p want=0,1,2,3,4", fetch_log);
        end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL basic_halt_req got=%0b want=0", imem_req); end
    endtask

    task automatic test_carry();
        clear_prog();
        prog[0] = enc(LDI, 1, 0, 0, 16'h00FF);
        prog[1] = enc(LDI, 2, 0, 0, 16'h0001);
        prog[2] = enc(ADD, 3, 1, 2, 0);
        prog[3] = enc(OUT, 0, 3, 0, 0);
        start(0);
        run_to_halt("carry_add");
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL add_wrap_dout got=%0h want=00", dout); end
        total++; if (flags !== 8'h0B) begin bad++; $display("FAIL add_wrap_flags got=%0h want=0b", flags); end

        prog[3] = enc(SUB, 4, 2, 1, 0);
        prog[4] = enc(OUT, 0, 4, 0, 0);
        start(1);
        run_to_halt("carry_sub");
        total++; if (dout !== 8'h02) begin bad++; $display("FAIL sub_borrow_dout got=%0h want=02", dout); end
        total++; if (flags !== 8'h0A) begin bad++; $display("FAIL sub_borrow_flags got=%0h want=0a", flags); end

        clear_prog();
        prog[0] = enc(LDI, 1, 0, 0, 16'h00C3);
        prog[1] = enc(SHL, 1, 1, 0, 0);
        prog[2] = enc(OUT, 0, 1, 0, 0);
        prog[3] = enc(LDI, 2, 0, 0, 16'h00F0);
        prog[4] = enc(AND_, 3, 1, 2, 0);
        prog[5] = enc(OUT, 0, 3, 0, 0);
        prog[6] = enc(NOP, 0, 0, 0, 0);
        start(0);
        run_to_halt("shl_and");
        total++; if (dout !== 8'h80) begin bad++; $display("FAIL and_dout got=%0h want=80", dout); end
        total++; if (flags !== 8'h0C) begin bad++; $display("FAIL and_flags got=%0h want=0c", flags); end
        total++; if (pulse_cnt != 2) begin bad++; $display("FAIL shl_pulses got=%0d want=2", pulse_cnt); end
    endtask

    task automatic test_loop();
        int subs = 0;
        clear_prog();
        prog[0] = enc(LDI, 1, 0, 0, 16'd3);
        prog[1] = enc(LDI, 2, 0, 0, 16'd1);
        prog[2] = enc(SUB, 1, 1, 2, 0);
        prog[3] = enc(JZ, 0, 1, 0, 16'd5);
        prog[4] = enc(JMP, 0, 0, 0, 16'd2);
        prog[5] = enc(OUT, 0, 1, 0, 0);
        start(2);
        run_to_halt("loop");
        foreach (fetch_log[i]) if (fetch_log[i] == 8'd2) subs++;
        total++; if (subs != 3) begin bad++; $display("FAIL loop_sub_count got=%0d want=3", subs); end
        total++; if (fetch_log.size() != 12) begin bad++; $display("FAIL loop_fetches got=%0d want=12", fetch_log.size()); end
        total++; if (dout !== 8'd0 || pulse_cnt != 1) begin bad++; $display("FAIL loop_dout got=%0h/%0d want=0/1", dout, pulse_cnt); end
        total++; if (flags !== 8'h09) begin bad++; $display("FAIL loop_flags got=%0h want=09", flags); end
    endtask

    task automatic test_jg();
        clear_prog();
        prog[0]     = enc(JG, 0, 0, 0, 16'h0013);
        prog[1]     = enc(JG, 0, 0, 0, 16'h0024);
        prog[8'h24] = enc(LDI, 1, 0, 0, 16'h005A);
        prog[8'h25] = enc(OUT, 0, 1, 0, 0);
        gpi = 4'b0100;
        start(0);
        run_to_halt("jg");
        gpi = 4'b0000;
        total++; if (dout !== 8'h5A) begin bad++; $display("FAIL jg_dout got=%0h want=5a", dout); end
        total++;
        if (fetch_log.size() < 3 || fetch_log[1] != 8'h01 || fetch_log[2] != 8'h24) begin
            bad++; $display("FAIL jg_path got=%p want=0,1,24,...", fetch_log);
        end
    endtask

    task automatic test_stack();
`ifdef CPU_CALL_STACK_EN
        clear_prog();
        prog[0] = enc(CALL, 0, 0, 0, 16'd4);
        prog[1] = enc(OUT, 0, 1, 0, 0);
        prog[4] = enc(LDI, 1, 0, 0, 16'h0033);
        prog[5] = enc(RET, 0, 0, 0, 0);
        start(0);
        run_to_halt("call_ret");
        total++; if (dout !== 8'h33 || fault !== 1'b0) begin bad++; $display("FAIL call_ret got=%0h/%0b want=33/0", dout, fault); end
        total++;
        if (fetch_log.size() != 5 || fetch_log[3] != 8'd1) begin
            bad++; $display("FAIL call_ret_path got=%p want=0,4,5,1,2", fetch_log);
        end

        clear_prog();
        prog[0] = enc(CALL, 0, 0, 0, 16'd5);
        prog[5] = enc(CALL, 0, 0, 0, 16'd9);
        prog[9] = enc(CALL, 0, 0, 0, 16'd12);
        start(1);
        run_to_halt("overflow");
        total++; if (fault !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL ovf_fault got=%0b/%0b want=1/1", fault, halted); end
        repeat (3) @(negedge clk);
        total++; if (imem_req !== 1'b0 || imem_addr !== 8'd9) begin bad++; $display("FAIL ovf_hold got=%0b/%0h want=0/09", imem_req, imem_addr); end

        clear_prog();
        prog[0] = enc(RET, 0, 0, 0, 0);
        start(0);
        run_to_halt("underflow");
        total++; if (fault !== 1'b1 || imem_addr !== 8'd0) begin bad++; $display("FAIL udf_fault got=%0b/%0h want=1/00", fault, imem_addr); end
`else
        clear_prog();
        prog[0] = enc(CALL, 0, 0, 0, 16'd5);
        prog[1] = enc(RET, 0, 0, 0, 0);
        prog[2] = enc(LDI, 1, 0, 0, 16'h0011);
        prog[3] = enc(OUT, 0, 1, 0, 0);
        start(0);
        run_to_halt("call_nop");
        total++; if (dout !== 8'h11 || fault !== 1'b0) begin bad++; $display("FAIL call_nop got=%0h/%0b want=11/0", dout, fault); end
        total++;
        if (fetch_log.size() != 5 || fetch_log[1] != 8'd1 || fetch_log[2] != 8'd2) begin
            bad++; $display("FAIL call_nop_path got=%p want=0,1,2,3,4", fetch_log);
        end
`endif
    endtask

    task automatic test_enable();
        load_basic();
        start(1);
        fork
            run_to_halt("enable");
            begin
                int n = 0;
                while (!halted && n < 500) begin
                    @(posedge clk); #1;
                    enable = ~enable;
                    n++;
                end
                enable = 1'b1;
            end
        join
        total++; if (dout !== 8'd8 || pulse_cnt != 1) begin bad++; $display("FAIL en_dout got=%0h/%0d want=8/1", dout, pulse_cnt); end
        total++; if (dv_off_cnt != 0) begin bad++; $display("FAIL en_dv_when_off got=%0d want=0", dv_off_cnt); end
        total++;
        if (fetch_log.size() != 5 || fetch_log[2] != 8'd2 || fetch_log[3] != 8'd3) begin
            bad++; $display("FAIL en_addr_seq got=%p want=0,1,2,3,4", fetch_log);
        end
    endtask

    task automatic test_reset_midfetch();
        int n = 0;
        load_basic();
        start(3);
        while (!(imem_req && imem_addr == 8'd2) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (!(imem_req && imem_addr == 8'd2)) begin bad++; $display("FAIL mid_reach got=%0h want=02", imem_addr); end
        @(posedge clk); #1;
        reset = 1'b1;
        clear_prog();
        prog[0] = enc(LDI, 9, 0, 0, 16'd1);
        prog[1] = enc(ADD, 4, 1, 9, 0);
        prog[2] = enc(OUT, 0, 4, 0, 0);
        prog[3] = enc(NOP, 0, 0, 0, 0);
        @(posedge clk); #1;
        total++; if (imem_addr !== 8'd0 || imem_req !== 1'b0) begin bad++; $display("FAIL mid_rst got=%0h/%0b want=00/0", imem_addr, imem_req); end
        fetch_log.delete();
        pulse_cnt = 0;
        reset = 1'b0;
        lat = 0;
        run_to_halt("mid_rerun");
        total++; if (dout !== 8'd1) begin bad++; $display("FAIL mid_regs_zero got=%0h want=01", dout); end
        total++; if (flags !== 8'h08 || flags[3] !== 1'b1) begin bad++; $display("FAIL mid_halt_flags got=%0h want=08", flags); end
        total++; if (fetch_log.size() != 5 || fetch_log[4] != 8'd4) begin bad++; $display("FAIL mid_halt_ip got=%p want=0..4", fetch_log); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_halt_req got=%0b want=0", imem_req); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_loop();
        test_jg();
        test_stack();
        test_enable();
        test_reset_midfetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
